// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

    localparam int unsigned DEFAULT_WIDTH = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : countdown_pkg

// File: rtl/countdown_tc.sv
// Terminal-count detection and registered one-cycle done pulse.
module countdown_tc
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  state_e           state,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] count,
    output logic             tc_c,
    output logic             done
);

    logic done_d;

    // Terminal edge: last enabled decrement of an active countdown.
    always_comb begin
        tc_c   = (state == RUN) && en && (count == WIDTH'(1));
        done_d = tc_c && !load;
    end

    // Done pulse register; a coincident load suppresses the pulse.
    always_ff @(posedge clk) begin
        if (res) begin
            done <= 1'b0;
        end else begin
            done <= done_d;
        end
    end

endmodule : countdown_tc

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause and one-cycle done pulse.
// Optional build macro: COUNTDOWN_AUTORELOAD_EN (periodic reload at terminal count).
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_c;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    countdown_tc #(
        .WIDTH (WIDTH)
    ) u_tc (
        .clk   (clk),
        .res   (res),
        .state (state_q),
        .en    (en),
        .load  (load),
        .count (count_q),
        .tc_c  (tc_c),
        .done  (done)
    );

    // State, counter and reload registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= IDLE;
            count_q  <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Next state and counter: load beats counting; decrement never wraps.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            if (load_val != '0) begin
                count_d  = load_val;
                state_d  = RUN;
`ifdef COUNTDOWN_AUTORELOAD_EN
                reload_d = load_val;
`endif
            end else begin
                count_d = '0;
                state_d = IDLE;
            end
        end else if (state_q == RUN && en) begin
            if (tc_c) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                count_d = reload_q;
                state_d = RUN;
`else
                count_d = '0;
                state_d = IDLE;
`endif
            end else if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                // Unreachable guard: an empty countdown simply stops.
                state_d = IDLE;
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer against a behavioural reference model.
`timescale 1ns/1ps
module tb_countdown_timer;

    localparam int unsigned W = 7;

    logic         clk = 1'b0;
    logic         res;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Reference model: a countdown is "period" enabled edges long; the
    // displayed count is whatever remains, and 0 whenever nothing is running.
    bit m_run    = 1'b0;
    int m_period = 0;
    int m_elapsed = 0;
    bit m_done   = 1'b0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .res      (res),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit r, input bit l, input int v, input bit e);
        m_done = 1'b0;
        if (r) begin
            m_run = 1'b0; m_period = 0; m_elapsed = 0;
        end else if (l) begin
            m_run = (v != 0); m_period = v; m_elapsed = 0;
        end else if (m_run && e) begin
            m_elapsed++;
            if (m_elapsed == m_period) begin
                m_done = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                m_elapsed = 0;
`else
                m_run = 1'b0;
`endif
            end
        end
    endfunction

    function automatic int m_count();
        return m_run ? (m_period - m_elapsed) : 0;
    endfunction

    // One clock: drive, advance the model at the edge, compare at the falling edge.
    task automatic cyc(input bit r, input bit l, input int v, input bit e);
        res = r; load = l; load_val = W'(v); en = e;
        @(posedge clk);
        model_edge(r, l, v, e);
        @(negedge clk);
        check("count", 32'(count), m_count());
        check("busy",  32'(busy),  32'(m_run));
        check("done",  32'(done),  32'(m_done));
    endtask

    int done_seen;

    initial begin
        res = 1'b1; load = 1'b1; load_val = W'(5); en = 1'b1;
        @(negedge clk);

        // Reset dominates load
        cyc(1, 1, 5, 1);
        cyc(1, 1, 5, 1);
        check("rst_count", 32'(count), 0);
        check("rst_busy",  32'(busy),  0);
        check("rst_done",  32'(done),  0);

`ifndef COUNTDOWN_AUTORELOAD_EN
        // One-shot: 5,4,3,2,1,0 with done alongside the 0
        cyc(0, 1, 5, 1);
        check("os_load", 32'(count), 5);
        for (int i = 4; i >= 1; i--) cyc(0, 0, 0, 1);
        check("os_one", 32'(count), 1);
        cyc(0, 0, 0, 1);
        check("os_zero", 32'(count), 0);
        check("os_done", 32'(done), 1);
        check("os_busy", 32'(busy), 0);
        cyc(0, 0, 0, 1);
        check("os_done_once", 32'(done), 0);

        // Pause: hold at 2 for three cycles, done three cycles later than usual
        cyc(0, 1, 4, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check("pause_hold", 32'(count), 2);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("pause_done", 32'(done), 1);
`endif

        // Collision: load 6 exactly on the terminal edge restarts without done
        cyc(0, 1, 3, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("coll_at_one", 32'(count), 1);
        cyc(0, 1, 6, 1);
        check("coll_count", 32'(count), 6);
        check("coll_done",  32'(done),  0);
        check("coll_busy",  32'(busy),  1);
        cyc(0, 1, 0, 1);
        check("zero_count", 32'(count), 0);
        check("zero_busy",  32'(busy),  0);
        check("zero_done",  32'(done),  0);

        // Reset mid-run: no done ever afterwards without a new load
        cyc(0, 1, 100, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        done_seen = 0;
        for (int i = 0; i < 120; i++) begin
            cyc(0, 0, 0, 1);
            if (done) done_seen++;
        end
        check("rst_mid_nodone", done_seen, 0);
        check("rst_mid_count", 32'(count), 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Auto-reload: period 3, count 3,2,1,3,... and busy stays high
        cyc(0, 1, 3, 1);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 1);
            check("ar_busy", 32'(busy), 1);
            check("ar_seq", 32'(count), 3 - ((i + 1) % 3));
            if (done) done_seen++;
        end
        check("ar_pulses", done_seen, 3);
`endif

        // Random traffic, biased toward short loads so terminal edges are common
        for (int i = 0; i < 3000; i++) begin
            bit r, l, e;
            int v;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 10);
            e = ($urandom_range(0, 99) < 80);
            case ($urandom_range(0, 3))
                0:       v = 0;
                1:       v = $urandom_range(0, (1 << W) - 1);
                default: v = $urandom_range(1, 6);
            endcase
            cyc(r, l, v, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_countdown_timer
